// File: rtl/ternary_vector_alu.sv
// ternary_vector_alu
//   Multi-lane ternary accumulate unit. Each beat carries LANES weight/trit
//   pairs. Every lane computes w*x in {-1,0,+1} and folds it into its own
//   signed accumulator according to the frame's op mode. When the frame
//   closes, the lane accumulators are summed into out_sum in one REDUCE
//   cycle. The result is then held in DRAIN until the downstream handshake.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   exec_hints          [7:0] op_mode, [17] zero_skip_en, [30:29] pool_op
//   in_valid/in_ready   input beat handshake
//   weight_vec/trit_vec 2 bits per lane: 00=0, 01=+1, 10=-1, 11=0
//   in_last             beat closes the frame
//   acc_clear           clear accumulators and overflow flags (IDLE/ACCUM only)
//   out_valid/out_ready frame result handshake
//   out_acc, out_sum    per-lane snapshot and full-width signed lane sum
//   overflow            sticky per-lane overflow flags
//   skip_count          wrapping count of zero-skipped lane operations
//   active_cycles       wrapping count of accepted beats
module ternary_vector_alu #(
  parameter int LANES  = 8,
  parameter int ACC_W  = 32,
  parameter bit SAT_EN = 1'b1,
  parameter int SUM_W  = ACC_W + $clog2(LANES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              exec_hints,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*LANES-1:0]       weight_vec,
  input  logic [2*LANES-1:0]       trit_vec,
  input  logic                     in_last,
  input  logic                     acc_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W*LANES-1:0]   out_acc,
  output logic signed [SUM_W-1:0]  out_sum,
  output logic [LANES-1:0]         overflow,
  output logic [31:0]              skip_count,
  output logic [31:0]              active_cycles
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_REDUCE = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  localparam logic [7:0] OP_DOT   = 8'h01;
  localparam logic [7:0] OP_MUL   = 8'h03;
  localparam logic [7:0] OP_TCONV = 8'h04;
  localparam logic [7:0] OP_POOL  = 8'h05;
  localparam logic [7:0] OP_TGEMM = 8'h06;

  localparam logic [1:0] POOL_MAX = 2'd0;
  localparam logic [1:0] POOL_MIN = 2'd1;
  localparam logic [1:0] POOL_AVG = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [7:0]              op_q, op_d;
  logic                    zskip_q, zskip_d;
  logic [1:0]              pool_q, pool_d;
  logic [31:0]             skip_q, skip_d;
  logic [31:0]             active_q, active_d;
  logic [ACC_W*LANES-1:0]  out_acc_q, out_acc_d;
  logic signed [SUM_W-1:0] out_sum_q, out_sum_d;

  logic       beat, first_beat, clr_en, drain_hs;
  logic [7:0] op_eff;
  logic       zskip_eff;
  logic [1:0] pool_eff;

  logic [ACC_W*LANES-1:0]  acc_flat;
  logic [LANES-1:0]        ovf_flat;
  logic [LANES-1:0]        skip_vec;
  logic [31:0]             skip_inc;
  logic signed [SUM_W-1:0] lane_sum;
  logic [ACC_W-1:0]        lane_val;

  logic unused_hints;
  assign unused_hints = ^{exec_hints[31], exec_hints[28:18], exec_hints[16:8]};

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DRAIN);
  assign beat      = in_valid && in_ready;
  assign clr_en    = acc_clear && in_ready;
  assign drain_hs  = out_valid && out_ready;
  // A beat that arrives with a clear restarts the frame, so it behaves as a first beat.
  assign first_beat = beat && ((state_q == ST_IDLE) || acc_clear);

  // The first beat uses the live hints. Later beats use the copy latched on that beat.
  assign op_eff    = first_beat ? exec_hints[7:0]   : op_q;
  assign zskip_eff = first_beat ? exec_hints[17]    : zskip_q;
  assign pool_eff  = first_beat ? exec_hints[30:29] : pool_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [1:0]              w, x;
    logic                    w_nz, x_nz, p_pos, p_neg, skip;
    logic signed [ACC_W-1:0] prod, base, add_res, acc_q, acc_d;
    logic signed [ACC_W:0]   add_wide;
    logic                    add_ovf, ovf_q, ovf_d;

    assign w = weight_vec[2*gi +: 2];
    assign x = trit_vec[2*gi +: 2];
    // The 11 code decodes as zero, so a lane is non-zero only for 01 or 10.
    assign w_nz  = w[0] ^ w[1];
    assign x_nz  = x[0] ^ x[1];
    assign p_pos = w_nz && x_nz && (w == x);
    assign p_neg = w_nz && x_nz && (w != x);
    assign prod  = p_pos ? ACC_W'(1) : (p_neg ? '1 : '0);
    assign skip  = zskip_eff && !(w_nz && x_nz);

    // A clear in the same cycle as a beat applies the beat to zero.
    assign base     = clr_en ? '0 : acc_q;
    assign add_wide = {base[ACC_W-1], base} + {prod[ACC_W-1], prod};
    assign add_ovf  = add_wide[ACC_W] ^ add_wide[ACC_W-1];

    always_comb begin
      add_res = add_wide[ACC_W-1:0];
      if (add_ovf && SAT_EN) begin
        // The extra top bit holds the true sign of the unbounded sum.
        add_res = add_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end

    always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (drain_hs || clr_en) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      if (beat && !skip) begin
        case (op_eff)
          OP_DOT, OP_TCONV, OP_TGEMM: begin
            acc_d = add_res;
            ovf_d = ovf_d | add_ovf;
          end
          OP_MUL: acc_d = prod;
          OP_POOL: begin
            case (pool_eff)
              POOL_MAX: acc_d = (first_beat || (prod > base)) ? prod : base;
              POOL_MIN: acc_d = (first_beat || (prod < base)) ? prod : base;
              POOL_AVG: begin
                acc_d = add_res;
                ovf_d = ovf_d | add_ovf;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
    end

    assign acc_flat[gi*ACC_W +: ACC_W] = acc_q;
    assign ovf_flat[gi]                = ovf_q;
    assign skip_vec[gi]                = beat && skip;
  end

  // Full-width sum. SUM_W has enough headroom, so this sum never saturates.
  always_comb begin
    lane_sum = '0;
    lane_val = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_val = acc_flat[i*ACC_W +: ACC_W];
      lane_sum = lane_sum + {{(SUM_W-ACC_W){lane_val[ACC_W-1]}}, lane_val};
    end
  end

  always_comb begin
    skip_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      skip_inc = skip_inc + 32'(skip_vec[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    zskip_d   = zskip_q;
    pool_d    = pool_q;
    skip_d    = skip_q;
    active_d  = active_q;
    out_acc_d = out_acc_q;
    out_sum_d = out_sum_q;
    case (state_q)
      ST_IDLE:   if (beat) state_d = in_last ? ST_REDUCE : ST_ACCUM;
      ST_ACCUM:  if (beat && in_last) state_d = ST_REDUCE;
      ST_REDUCE: state_d = ST_DRAIN;
      ST_DRAIN:  if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (first_beat) begin
      op_d    = exec_hints[7:0];
      zskip_d = exec_hints[17];
      pool_d  = exec_hints[30:29];
    end
    if (beat) begin
      active_d = active_q + 32'd1;
      skip_d   = skip_q + skip_inc;
    end
    if (state_q == ST_REDUCE) begin
      out_acc_d = acc_flat;
      out_sum_d = lane_sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      zskip_q   <= 1'b0;
      pool_q    <= '0;
      skip_q    <= '0;
      active_q  <= '0;
      out_acc_q <= '0;
      out_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      zskip_q   <= zskip_d;
      pool_q    <= pool_d;
      skip_q    <= skip_d;
      active_q  <= active_d;
      out_acc_q <= out_acc_d;
      out_sum_q <= out_sum_d;
    end
  end

  assign out_acc       = out_acc_q;
  assign out_sum       = out_sum_q;
  assign overflow      = ovf_flat;
  assign skip_count    = skip_q;
  assign active_cycles = active_q;

endmodule

// File: tb/tb_ternary_vector_alu.sv
module tb_ternary_vector_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [31:0]       exec_hints;
  logic              in_valid, in_last, acc_clear, out_ready;
  logic [15:0]       weight_vec, trit_vec;

  logic              in_ready, out_valid;
  logic [255:0]      out_acc;
  logic signed [34:0] out_sum;
  logic [7:0]        overflow;
  logic [31:0]       skip_count, active_cycles;

  logic              in_ready_s, out_valid_s, in_ready_w, out_valid_w;
  logic [31:0]       out_acc_s, out_acc_w;
  logic signed [6:0] out_sum_s, out_sum_w;
  logic [7:0]        overflow_s, overflow_w;
  logic [31:0]       skip_count_s, active_cycles_s, skip_count_w, active_cycles_w;

  ternary_vector_alu #(.LANES(8), .ACC_W(32), .SAT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .exec_hints(exec_hints), .in_valid(in_valid), .in_ready(in_ready),
    .weight_vec(weight_vec), .trit_vec(trit_vec), .in_last(in_last), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_sum(out_sum),
    .overflow(overflow), .skip_count(skip_count), .active_cycles(active_cycles));

  ternary_vector_alu #(.LANES(8), .ACC_W(4), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .exec_hints(exec_hints), .in_valid(in_valid), .in_ready(in_ready_s),
    .weight_vec(weight_vec), .trit_vec(trit_vec), .in_last(in_last), .acc_clear(acc_clear),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_acc(out_acc_s), .out_sum(out_sum_s),
    .overflow(overflow_s), .skip_count(skip_count_s), .active_cycles(active_cycles_s));

  ternary_vector_alu #(.LANES(8), .ACC_W(4), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .exec_hints(exec_hints), .in_valid(in_valid), .in_ready(in_ready_w),
    .weight_vec(weight_vec), .trit_vec(trit_vec), .in_last(in_last), .acc_clear(acc_clear),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_acc(out_acc_w), .out_sum(out_sum_w),
    .overflow(overflow_w), .skip_count(skip_count_w), .active_cycles(active_cycles_w));

  logic unused_small;
  assign unused_small = ^{in_ready_s, out_valid_s, in_ready_w, out_valid_w, skip_count_s,
                          active_cycles_s, skip_count_w, active_cycles_w};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  function automatic longint lane(input logic [255:0] v, input int i);
    logic [31:0] t;
    t = v[i*32 +: 32];
    return longint'($signed(t));
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; acc_clear = 1'b0; out_ready = 1'b0;
    exec_hints = '0; weight_vec = '0; trit_vec = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] w, input logic [15:0] x, input logic [31:0] h,
                      input logic last, input logic clr);
    int t;
    t = 0;
    weight_vec = w; trit_vec = x; exec_hints = h; in_last = last; acc_clear = clr; in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready got 0, expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; acc_clear = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 10) begin
      @(posedge clk); #1; t++;
    end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL out_valid_timeout: got 0, expected 1 within 10 cycles");
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Behavioural reference: integer lane values updated from the op rules.
  longint      m_acc[8];
  logic [31:0] m_skip, m_active, m_hints;
  bit          m_in_frame;

  function automatic int tv(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b10:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic model_beat(input logic [15:0] w, input logic [15:0] x, input logic [31:0] h,
                            input logic last);
    bit  first;
    int  wv, xv, p;
    first = !m_in_frame;
    if (first) m_hints = h;
    m_active = m_active + 1;
    for (int i = 0; i < 8; i++) begin
      wv = tv(w[2*i +: 2]);
      xv = tv(x[2*i +: 2]);
      p  = wv * xv;
      if (m_hints[17] && (wv == 0 || xv == 0)) begin
        m_skip = m_skip + 1;
      end else if (m_hints[7:0] == 8'h01 || m_hints[7:0] == 8'h04 || m_hints[7:0] == 8'h06) begin
        m_acc[i] = clamp32(m_acc[i] + p);
      end else if (m_hints[7:0] == 8'h03) begin
        m_acc[i] = p;
      end else if (m_hints[7:0] == 8'h05) begin
        case (m_hints[30:29])
          2'd0: if (first || p > m_acc[i]) m_acc[i] = p;
          2'd1: if (first || p < m_acc[i]) m_acc[i] = p;
          2'd2: m_acc[i] = clamp32(m_acc[i] + p);
          default: ;
        endcase
      end
    end
    m_in_frame = !last;
  endtask

  typedef struct {
    logic [31:0] hints;
    logic [15:0] w;
    logic [15:0] x;
    longint      exp_sum;
    int          exp_skip;
  } vec_t;

  vec_t        tbl[12];
  logic [7:0]  ops[7];
  logic [31:0] skip0, act0, h;
  logic [15:0] rw, rx;
  longint      sum0, lane0_0, msum;
  int          len, nvalid;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h0000_0001, 16'h5555, 16'h5555,  8, 0};
    tbl[1]  = '{32'h0000_0001, 16'h5555, 16'hAAAA, -8, 0};
    tbl[2]  = '{32'h0002_0003, 16'h5555, 16'h00FF,  0, 8};
    tbl[3]  = '{32'h0000_0006, 16'hAAAA, 16'h5555, -8, 0};
    tbl[4]  = '{32'h0000_0004, 16'h5559, 16'h5555,  6, 0};
    tbl[5]  = '{32'h0000_0002, 16'h5555, 16'h5555,  0, 0};
    tbl[6]  = '{32'h0000_0005, 16'h5555, 16'hAAAA, -8, 0};
    tbl[7]  = '{32'h6000_0005, 16'h5555, 16'h5555,  0, 0};
    tbl[8]  = '{32'h4000_0005, 16'h5555, 16'h5555,  8, 0};
    tbl[9]  = '{32'h0002_0001, 16'h5505, 16'h5555,  6, 2};
    tbl[10] = '{32'h2000_0005, 16'h5555, 16'hAAAA, -8, 0};
    tbl[11] = '{32'h0000_0001, 16'hFFFF, 16'h5555,  0, 0};
    ops = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h02, 8'h00};

    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", (out_acc == '0) ? 1 : 0, 1);
    check("rst_out_sum", out_sum, 0);
    check("rst_overflow", overflow, 0);
    check("rst_skip", skip_count, 0);
    check("rst_active", active_cycles, 0);

    // Single-beat frames from the vector table.
    for (int i = 0; i < 12; i++) begin
      skip0 = skip_count; act0 = active_cycles;
      send(tbl[i].w, tbl[i].x, tbl[i].hints, 1'b1, 1'b0);
      wait_valid();
      check($sformatf("tbl%0d_sum", i), out_sum, tbl[i].exp_sum);
      check($sformatf("tbl%0d_skip", i), skip_count - skip0, tbl[i].exp_skip);
      check($sformatf("tbl%0d_active", i), active_cycles - act0, 1);
      handshake();
    end

    // DOT, 3 beats, with latency and in_ready timing.
    do_reset();
    send(16'h5555, 16'h4949, 32'h1, 1'b0, 1'b0);
    send(16'h5555, 16'h4949, 32'h1, 1'b0, 1'b0);
    send(16'h5555, 16'h4949, 32'h1, 1'b1, 1'b0);
    check("dot_reduce_in_ready", in_ready, 0);
    check("dot_reduce_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("dot_n2_out_valid", out_valid, 1);
    check("dot_drain_in_ready", in_ready, 0);
    wait_valid();
    for (int i = 0; i < 8; i++)
      check($sformatf("dot_lane%0d", i), lane(out_acc, i), (i == 2 || i == 6) ? 0 : ((i == 1 || i == 5) ? -3 : 3));
    check("dot_sum", out_sum, 6);
    handshake();

    // Zero-skip.
    do_reset();
    send(16'h5555, 16'h4545, 32'h0002_0001, 1'b0, 1'b0);
    send(16'h5555, 16'h4545, 32'h0000_0001, 1'b1, 1'b0);
    wait_valid();
    check("zs_skip", skip_count, 4);
    check("zs_active", active_cycles, 2);
    check("zs_lane2", lane(out_acc, 2), 0);
    check("zs_lane6", lane(out_acc, 6), 0);
    check("zs_sum", out_sum, 12);
    handshake();

    // Saturation and wrap on 4-bit accumulators.
    do_reset();
    for (int b = 0; b < 9; b++) send(16'h0001, 16'h0001, 32'h1, b == 8, 1'b0);
    wait_valid();
    check("sat_acc0", longint'($signed(out_acc_s[3:0])), 7);
    check("sat_ovf", overflow_s, 8'h01);
    check("sat_sum", out_sum_s, 7);
    check("wrap_acc0", longint'($signed(out_acc_w[3:0])), -7);
    check("wrap_ovf", overflow_w, 8'h01);
    check("wrap_sum", out_sum_w, -7);
    check("wide_acc0", lane(out_acc, 0), 9);
    check("wide_ovf", overflow, 0);
    handshake();
    check("ovf_cleared_on_hs", overflow_s, 0);

    // POOL MAX over [-1,-1,+1,-1], then MIN over all +1.
    send(16'h0001, 16'h0002, 32'h0000_0005, 1'b0, 1'b0);
    send(16'h0001, 16'h0002, 32'h0000_0005, 1'b0, 1'b0);
    send(16'h0001, 16'h0001, 32'h0000_0005, 1'b0, 1'b0);
    send(16'h0001, 16'h0002, 32'h0000_0005, 1'b1, 1'b0);
    wait_valid();
    check("pmax_acc0", lane(out_acc, 0), 1);
    handshake();
    for (int b = 0; b < 3; b++) send(16'h5555, 16'h5555, 32'h2000_0005, b == 2, 1'b0);
    wait_valid();
    check("pmin_acc0", lane(out_acc, 0), 1);
    check("pmin_sum", out_sum, 8);
    handshake();

    // Backpressure in DRAIN with a beat waiting.
    do_reset();
    send(16'h5555, 16'h5555, 32'h1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("bp_out_valid", out_valid, 1);
    in_valid = 1'b1; weight_vec = 16'h0005; trit_vec = 16'h0005; in_last = 1'b1; exec_hints = 32'h1;
    act0 = active_cycles; sum0 = out_sum; lane0_0 = lane(out_acc, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_sum_stable", out_sum, sum0);
      check("bp_lane0_stable", lane(out_acc, 0), lane0_0);
      check("bp_no_accept", active_cycles, act0);
    end
    handshake();
    check("bp_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_next_beat", active_cycles, act0 + 1);
    wait_valid();
    check("bp_cleared_sum", out_sum, 2);
    handshake();

    // Asynchronous reset mid-ACCUM.
    send(16'h5555, 16'h5555, 32'h1, 1'b0, 1'b0);
    send(16'h5555, 16'h5555, 32'h1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_acc", (out_acc == '0) ? 1 : 0, 1);
    check("arst_out_sum", out_sum, 0);
    check("arst_active", active_cycles, 0);
    #2 reset = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) nvalid++;
    end
    check("arst_no_out_valid", nvalid, 0);

    // acc_clear with a beat in IDLE, and alone in ACCUM.
    do_reset();
    send(16'h5555, 16'h5555, 32'h1, 1'b1, 1'b1);
    wait_valid();
    check("clr_idle_sum", out_sum, 8);
    handshake();
    send(16'h5555, 16'h5555, 32'h1, 1'b0, 1'b0);
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    send(16'h0005, 16'h0005, 32'h1, 1'b1, 1'b0);
    wait_valid();
    check("clr_accum_sum", out_sum, 2);
    check("clr_accum_lane2", lane(out_acc, 2), 0);
    check("clr_counters_kept", active_cycles, 3);
    handshake();

    // Randomized frames against the reference model.
    do_reset();
    m_skip = 0; m_active = 0; m_in_frame = 0; m_hints = 0;
    for (int i = 0; i < 8; i++) m_acc[i] = 0;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        rw = 16'($urandom);
        rx = 16'($urandom);
        h = $urandom;
        h[7:0] = ops[$urandom_range(0, 6)];
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send(rw, rx, h, b == len - 1, 1'b0);
        model_beat(rw, rx, h, b == len - 1);
      end
      wait_valid();
      msum = 0;
      for (int i = 0; i < 8; i++) begin
        check($sformatf("rnd%0d_lane%0d", f, i), lane(out_acc, i), m_acc[i]);
        msum = msum + m_acc[i];
      end
      check($sformatf("rnd%0d_sum", f), out_sum, msum);
      check($sformatf("rnd%0d_skip", f), skip_count, m_skip);
      check($sformatf("rnd%0d_active", f), active_cycles, m_active);
      handshake();
      for (int i = 0; i < 8; i++) m_acc[i] = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ternary_vector_alu.md
Name: ternary_vector_alu

Overview:
- Parametrised, multi-lane successor of the single-lane ternary processing element.
- Takes LANES packed trit pairs per beat over a valid/ready stream and keeps one signed accumulator per lane. Supports optional saturation, frame-based operation, and a registered cross-lane reduction.
- Sits between the trit unpacker/stream fetch and the result writeback DMA in the fabric datapath.

Parameters:
- LANES, 8, number of parallel ternary lanes (≥2, power of two).
- ACC_W, 32, per-lane accumulator width in bits, signed.
- SAT_EN, 1, 1 = accumulators clamp on overflow; 0 = accumulators wrap (two's complement).
- SUM_W, ACC_W+$clog2(LANES), width of the reduction output (derived; do not override).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- exec_hints  in  32  [7:0] op_mode, [17] zero_skip_en, [30:29] pool_op; sampled on a frame's first beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- weight_vec  in  2*LANES  lane i weight at [2i+1:2i]; encoding 00=0, 01=+1, 10=-1, 11 treated as 0.
- trit_vec  in  2*LANES  lane i input trit, same encoding.
- in_last  in  1  beat closes the frame.
- acc_clear  in  1  synchronous clear of accumulators and overflow flags.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W*LANES  per-lane final accumulators.
- out_sum  out  SUM_W  signed sum of all lane accumulators.
- overflow  out  LANES  sticky per-lane overflow flags.
- skip_count  out  32  total skipped lane-operations, wrapping.
- active_cycles  out  32  total accepted beats, wrapping.

Behaviour:
- Reset values: all outputs 0, except in_ready=1. Accumulators 0, state IDLE. Reset mid-frame aborts the frame; no output is produced.
- Beat: accepted when in_valid && in_ready.
- in_ready: 1 in IDLE and ACCUM; 0 in REDUCE and DRAIN.
- Product, per lane: w*x in {-1,0,+1}, sign-extended to ACC_W.
- Zero-skip: when zero_skip_en=1, a lane with w==0 or x==0 is skipped. Its accumulator is untouched, including under MUL and POOL. skip_count increments by the popcount of skipped lanes in the beat.
- active_cycles: +1 per accepted beat.
- Op modes, per non-skipped lane:
  - 0x01/0x04/0x06 (DOT/T-CONV/TGEMM): acc += product.
  - 0x03 (MUL): acc = product.
  - 0x05 (T-POOL): pool_op 00=MAX, 01=MIN, 10=AVG-accumulate, 11=no-op. On the first beat of a frame, MAX/MIN load the product directly instead of comparing.
  - Any other op_mode: accumulators hold; counters still count.
- Overflow: when a signed add leaves the ACC_W range, set that lane's overflow bit. With SAT_EN=1, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1); with SAT_EN=0, wrap.
- Overflow clearing: flags clear only on reset, acc_clear, or the out handshake.
- exec_hints latching: latched on the first beat of a frame (IDLE→ACCUM or IDLE→REDUCE). Changes to exec_hints mid-frame are ignored.
- FSM:
  - IDLE: a beat with in_last=0 → ACCUM; a beat with in_last=1 → REDUCE.
  - ACCUM: a beat with in_last=1 → REDUCE.
  - REDUCE: one cycle; registers out_sum = signed sum of the accumulators at full SUM_W (never saturates); snapshots out_acc → DRAIN.
  - DRAIN: out_valid=1 with out_acc/out_sum stable until out_ready. On the handshake: accumulators and overflow flags → 0, state → IDLE.
- Latency: last beat accepted in cycle N → out_valid asserted in cycle N+2.
- Minimum frame spacing: 3 cycles.
- acc_clear:
  - Honoured only in IDLE/ACCUM; ignored in REDUCE/DRAIN.
  - If asserted in the same cycle as an accepted beat, clear happens first, then the beat is applied to zero. The beat counts as the frame's first beat.
  - Does not change the FSM state and does not touch the counters.
- Counters wrap from 2^32-1 to 0.
- Single-beat frame (in_last on the first beat) is legal.
- out_ready held high during REDUCE has no effect until DRAIN.

Test Plan:
- DOT, LANES=8: 3 beats with all weights +1, trits [+1,-1,0,+1,+1,-1,0,+1], last on beat 3. Required: out_acc lanes = [3,-3,0,3,3,-3,0,3]; out_sum=6; out_valid in cycle N+2; in_ready=0 during REDUCE and DRAIN.
- Zero-skip: hints 0x0002_0001, 2 beats with lanes 2 and 6 zero. Required: skip_count=4, active_cycles=2, lanes 2 and 6 stay 0.
- Saturation, ACC_W=4, SAT_EN=1: 9 beats of +1 on lane 0. Required: acc0=7, overflow[0]=1, other overflow bits 0. With SAT_EN=0: acc0=-7 after wrap, overflow[0]=1.
- POOL MAX, 4 beats of lane 0 products [-1,-1,+1,-1]. Required: acc0=+1. POOL MIN over all-(+1) products: acc0=+1 (first-beat load, not 0).
- Backpressure: out_ready held low 5 cycles in DRAIN, in_valid high throughout. Required: out_acc/out_sum stable; no beats accepted; after the handshake, accumulators are 0 and the next beat is accepted in the following cycle.
- Async reset asserted mid-ACCUM: outputs go to reset values immediately; no out_valid follows. acc_clear together with a beat in IDLE: accumulators equal that beat's products.
